// File: rtl/aes_pkg.sv
// AES-128 constants, S-box and single-round transform shared by the round stages.
// Latency: combinational helpers only.
// Backpressure: not applicable (no handshake here).
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_NUM_RKEYS = 11;
  localparam int AES_KS_W      = AES_BLOCK_W * AES_NUM_RKEYS;
  localparam int AES_LAST_RND  = AES_NUM_RKEYS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_stage_state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State byte i (column i/4, row i%4) lives at bits [127-8i -: 8], matching the
  // usual big-endian hex notation of test vectors. SubBytes and ShiftRows are fused.
  function automatic logic [127:0] aes_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = AES_SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c+0) -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c+0) -: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
    end
    return o;
  endfunction

  // One AES-128 encryption round r: 0 is the initial key add, 10 skips MixColumns.
  function automatic logic [127:0] fn_aes_encrypt_stage(input logic [127:0]  blk,
                                                        input logic [1407:0] ks,
                                                        input logic [3:0]    r);
    logic [3:0]   rsel;
    logic [127:0] rk;
    logic [127:0] s;
    rsel = (r > 4'(AES_LAST_RND)) ? 4'(AES_LAST_RND) : r;
    rk   = ks[128*int'(rsel) +: 128];
    if (rsel == 4'd0) begin
      s = blk;
    end else begin
      s = aes_sub_shift(blk);
      if (rsel != 4'(AES_LAST_RND)) begin
        s = aes_mix_columns(s);
      end
    end
    return s ^ rk;
  endfunction

endpackage

// File: rtl/aes_lane_round.sv
// One AES round on one 128-bit lane, round index chosen at run time.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage owns the handshake.
module aes_lane_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] blk_i,
  input  logic [AES_KS_W-1:0]    ks_i,
  input  logic [3:0]             round_i,
  output logic [AES_BLOCK_W-1:0] blk_o
);

  assign blk_o = fn_aes_encrypt_stage(blk_i, ks_i, round_i);

endmodule

// File: rtl/aes_round_pipe_stage.sv
// Runs ROUNDS_PER_STAGE AES rounds (from ROUND_START) on NUM_LANES masked lanes, key and sideband carried along.
// Latency: o_valid rises ROUNDS_PER_STAGE cycles after accept; one transaction per ROUNDS_PER_STAGE+1 cycles.
// Backpressure: result held in DONE while i_ready=0; o_ready only in IDLE or in DONE with i_ready (no bubble).
module aes_round_pipe_stage
  import aes_pkg::*;
#(
  parameter int NUM_LANES        = 3,
  parameter int ROUND_START      = 0,
  parameter int ROUNDS_PER_STAGE = 1,
  parameter int SIDEBAND_W       = 387
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_flush,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [NUM_LANES-1:0]             i_lane_en,
  input  logic [NUM_LANES*AES_BLOCK_W-1:0] i_blocks,
  input  logic [AES_KS_W-1:0]              i_key_schedule,
  input  logic [SIDEBAND_W-1:0]            i_sideband,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [NUM_LANES*AES_BLOCK_W-1:0] o_blocks,
  output logic [AES_KS_W-1:0]              o_key_schedule,
  output logic [SIDEBAND_W-1:0]            o_sideband
);

  if (ROUNDS_PER_STAGE < 1 || ROUND_START < 0 ||
      ROUND_START + ROUNDS_PER_STAGE > AES_NUM_RKEYS) begin : g_param_check
    $error("aes_round_pipe_stage: need ROUNDS_PER_STAGE>=1 and ROUND_START+ROUNDS_PER_STAGE<=11");
  end

  localparam int CNT_W = $clog2(ROUNDS_PER_STAGE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS_PER_STAGE - 1);

  aes_stage_state_e                 state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_LANES-1:0]             lane_en_q;
  logic [NUM_LANES*AES_BLOCK_W-1:0] blocks_q;
  logic [NUM_LANES*AES_BLOCK_W-1:0] blocks_rnd;
  logic [AES_KS_W-1:0]              key_q;
  logic [SIDEBAND_W-1:0]            sb_q;
  logic                             accept;
  logic                             load;
  logic                             advance;
  logic [3:0]                       round_idx;

  assign o_ready   = (state_q == IDLE) | ((state_q == DONE) & i_ready);
  assign accept    = i_valid & o_ready;
  assign round_idx = 4'(ROUND_START) + 4'(cnt_q);

  // Every lane computes the current round; the captured mask decides who takes it.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [AES_BLOCK_W-1:0] lane_out;

    aes_lane_round u_round (
      .blk_i   (blocks_q[l*AES_BLOCK_W +: AES_BLOCK_W]),
      .ks_i    (key_q),
      .round_i (round_idx),
      .blk_o   (lane_out)
    );

    assign blocks_rnd[l*AES_BLOCK_W +: AES_BLOCK_W] =
      lane_en_q[l] ? lane_out : blocks_q[l*AES_BLOCK_W +: AES_BLOCK_W];
  end

  // Next-state logic; flush overrides everything, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        advance = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          if (accept) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      load    = 1'b0;
      advance = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture on accept, update lanes while rounds run; otherwise hold (flush keeps data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_en_q <= '0;
      blocks_q  <= '0;
      key_q     <= '0;
      sb_q      <= '0;
    end else if (load) begin
      lane_en_q <= i_lane_en;
      blocks_q  <= i_blocks;
      key_q     <= i_key_schedule;
      sb_q      <= i_sideband;
    end else if (advance) begin
      blocks_q  <= blocks_rnd;
    end
  end

  assign o_valid        = (state_q == DONE);
  assign o_blocks       = blocks_q;
  assign o_key_schedule = key_q;
  assign o_sideband     = sb_q;

endmodule
